// File: rtl/hqc_params.sv
// -----------------------------------------------------------------------------
// hqc_params
// Shared constants and helpers for the HQC decapsulation FO-check datapath.
//   - HQC_WIDTH  : stream word width (128 bits)
//   - get_n()    : maps a parameter-set name ("hqc128"/"hqc192"/"hqc256")
//                  to the polynomial length N in bits
//   - get_depth(): number of WIDTH-bit words that cover N bits
//   - tail_bits(): valid bits in the last word (0 = full word)
//   - clog2()    : ceiling log2 for sizing counters and addresses
//   - state_e    : FSM encoding for xor_stream_compare
// No ports; imported by xor_stream_compare and popcount_w.
// -----------------------------------------------------------------------------
package hqc_params;

   localparam int HQC_WIDTH = 128;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_FLUSH1 = 3'd2,
      ST_FLUSH2 = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Ceiling log2; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Parameter-set name is carried as a 6-character packed string.
   function automatic int get_n(input logic [47:0] parameter_set);
      if (parameter_set == "hqc128") return 17_669;
      if (parameter_set == "hqc192") return 35_851;
      return 57_637;
   endfunction

   function automatic int get_depth(input int n, input int width);
      return (n + width - 1) / width;
   endfunction

   function automatic int tail_bits(input int n, input int width);
      return n % width;
   endfunction

endpackage : hqc_params

// File: rtl/xor_stream_compare_popcount_w.sv
// -----------------------------------------------------------------------------
// popcount_w
// WIDTH-bit population count with a single registered output stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : data_i carries a word to count this cycle
//   data_i     : word to count
//   valid_o    : count_o is valid (one cycle after valid_i)
//   count_o    : number of set bits in the word presented one cycle earlier
// Used by xor_stream_compare only when XOR_CMP_WEIGHT_EN is defined.
// -----------------------------------------------------------------------------
module popcount_w
   import hqc_params::*;
#(
   parameter int WIDTH = HQC_WIDTH,
   parameter int CW    = clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   logic [CW-1:0] count_d;

   // Written as a flat sum; synthesis balances it into an adder tree.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_d = count_d + CW'(data_i[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         count_o <= '0;
      end else begin
         valid_o <= valid_i;
         count_o <= valid_i ? count_d : '0;
      end
   end

endmodule : popcount_w

// File: rtl/xor_stream_compare.sv
// -----------------------------------------------------------------------------
// xor_stream_compare
// Consumes the re-encrypted-XOR-received difference stream of the HQC FO
// check. Each accepted word is trimmed of padding beyond N, written to the
// result RAM port and OR-accumulated; `equal` reports an all-zero difference.
// Optional feature macro: XOR_CMP_WEIGHT_EN adds a saturating Hamming-weight
// counter on output `weight`.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : arm for one comparison (accepted in IDLE only)
//   in_data/in_addr     : difference word and its word address
//   in_valid            : word strobe
//   in_done             : upstream end-of-stream pulse
//   wr_en/wr_addr/wr_data : registered result RAM write port
//   busy                : from start acceptance through DONE
//   done                : one-cycle completion pulse, 3 cycles after in_done
//   equal               : all DEPTH trimmed words zero, stream well-formed
//   error               : address mismatch or wrong word count
//   weight              : Hamming weight of the difference (macro only)
// -----------------------------------------------------------------------------
module xor_stream_compare
   import hqc_params::*;
#(
   parameter logic [47:0] parameter_set = "hqc256",
   parameter int N         = get_n(parameter_set),
   parameter int WIDTH     = HQC_WIDTH,
   parameter int N_MEM     = get_depth(N, WIDTH) * WIDTH,
   parameter int DEPTH     = N_MEM / WIDTH,
   parameter int LOG_DEPTH = clog2(DEPTH),
   parameter int TAIL_BITS = tail_bits(N, WIDTH),
   parameter int WW        = clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [LOG_DEPTH-1:0] in_addr,
   input  logic                 in_valid,
   input  logic                 in_done,
   output logic                 wr_en,
   output logic [LOG_DEPTH-1:0] wr_addr,
   output logic [WIDTH-1:0]     wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 equal,
   output logic                 error
`ifdef XOR_CMP_WEIGHT_EN
   ,
   output logic [WW-1:0]        weight
`endif
);

   // cnt must be able to hold DEPTH itself, one more than the last address.
   localparam int CW = clog2(DEPTH + 1);
   localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0]    LAST_C    = CW'(DEPTH - 1);
   localparam logic [WIDTH-1:0] ONES      = '1;
   localparam logic [WIDTH-1:0] TAIL_MASK = (TAIL_BITS == 0) ? ONES
                                          : (ONES >> (WIDTH - TAIL_BITS));

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 acc_or_q;   // OR of every trimmed bit seen so far
   logic                 busy_q;
   logic                 done_q;
   logic                 equal_q;
   logic                 error_q;
   logic                 wr_en_q;
   logic [LOG_DEPTH-1:0] wr_addr_q;
   logic [WIDTH-1:0]     wr_data_q;

   logic                 accept;
   logic [WIDTH-1:0]     word_trim;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      accept    = 1'b0;
      word_trim = in_data;
      if (state_q == ST_RUN && in_valid && cnt_q < DEPTH_C) begin
         accept = 1'b1;
      end
      if (cnt_q == LAST_C) begin
         word_trim = in_data & TAIL_MASK;
      end
   end

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_or_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         equal_q   <= 1'b0;
         error_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cnt_q    <= '0;
                  acc_or_q <= 1'b0;
                  error_q  <= 1'b0;
                  equal_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Words beyond DEPTH (upstream's surplus word) drop silently.
               if (accept) begin
                  if (CW'(in_addr) != cnt_q) begin
                     error_q <= 1'b1;
                  end
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cnt_q[LOG_DEPTH-1:0];
                  wr_data_q <= word_trim;
                  acc_or_q  <= acc_or_q | (|word_trim);
                  cnt_q     <= cnt_q + 1'b1;
               end
               if (in_done) begin
                  state_q <= ST_FLUSH1;
               end
            end
            ST_FLUSH1: begin
               state_q <= ST_FLUSH2;
            end
            ST_FLUSH2: begin
               // Verdict registers on entry to DONE so it is visible there.
               state_q <= ST_DONE;
               done_q  <= 1'b1;
               equal_q <= !acc_or_q && (cnt_q == DEPTH_C) && !error_q;
               if (cnt_q != DEPTH_C) begin
                  error_q <= 1'b1;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign equal   = equal_q;
   assign error   = error_q;

`ifdef XOR_CMP_WEIGHT_EN
   localparam int PCW = clog2(WIDTH + 1);

   logic            pc_valid;
   logic [PCW-1:0]  pc_count;
   logic [WW-1:0]   weight_q;
   logic [WW:0]     weight_sum;

   // Counts the registered write word: last word written at in_done+1,
   // counted at +2, summed at +3, so the total is final in DONE.
   popcount_w #(
      .WIDTH (WIDTH),
      .CW    (PCW)
   ) u_popcount (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (wr_en_q),
      .data_i  (wr_data_q),
      .valid_o (pc_valid),
      .count_o (pc_count)
   );

   always_comb begin
      weight_sum = {1'b0, weight_q} + (WW + 1)'(pc_count);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_q <= '0;
      end else if (state_q == ST_IDLE && start) begin
         weight_q <= '0;
      end else if (pc_valid) begin
         weight_q <= (weight_sum > (WW + 1)'(N)) ? WW'(N) : weight_sum[WW-1:0];
      end
   end

   assign weight = weight_q;
`endif

endmodule : xor_stream_compare

// File: tb/tb_xor_stream_compare.sv
// -----------------------------------------------------------------------------
// tb_xor_stream_compare
// Directed bench for xor_stream_compare configured as hqc128
// (N=17669, DEPTH=139, TAIL_BITS=5). Weight checks are compiled in when
// XOR_CMP_WEIGHT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xor_stream_compare;

   localparam int WIDTH     = 128;
   localparam int DEPTH     = 139;
   localparam int LOG_DEPTH = 8;
   localparam int WW        = 15;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     in_data = '0;
   logic [LOG_DEPTH-1:0] in_addr = '0;
   logic                 in_valid = 1'b0;
   logic                 in_done = 1'b0;
   logic                 wr_en;
   logic [LOG_DEPTH-1:0] wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 busy;
   logic                 done;
   logic                 equal;
   logic                 error;
`ifdef XOR_CMP_WEIGHT_EN
   logic [WW-1:0]        weight;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Write monitor state.
   int wr_cnt   = 0;
   int seq_err  = 0;
   int bad_addr = 0;
   int done_cnt = 0;
   int exp_addr = 0;
   logic [WIDTH-1:0]     mem       [0:255];
   logic [WIDTH-1:0]     stim_data [0:255];
   logic [LOG_DEPTH-1:0] stim_addr [0:255];

   xor_stream_compare #(
      .parameter_set ("hqc128")
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_data  (in_data),
      .in_addr  (in_addr),
      .in_valid (in_valid),
      .in_done  (in_done),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .equal    (equal),
      .error    (error)
`ifdef XOR_CMP_WEIGHT_EN
      ,
      .weight   (weight)
`endif
   );

   always #5 clk = ~clk;

   // Outputs are observed on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (wr_en) begin
         if (int'(wr_addr) != exp_addr) seq_err++;
         if (int'(wr_addr) >= DEPTH) bad_addr++;
         mem[wr_addr] = wr_data;
         wr_cnt++;
         exp_addr++;
      end
      if (done) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
      $fatal(1);
   end

   task automatic clear_stim();
      for (int i = 0; i < 256; i++) begin
         stim_data[i] = '0;
         stim_addr[i] = LOG_DEPTH'(i);
         mem[i]       = 'x;
      end
   endtask

   // Start, stream n_words from the stim tables back-to-back, pulse in_done,
   // then observe 8 cycles. lat = falling edges from in_done to done (-1: none).
   task automatic run_stream(input string tag, input int n_words, output int lat);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_cnt = 0; seq_err = 0; bad_addr = 0; done_cnt = 0; exp_addr = 0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_start_busy: got %b want 1", tag, busy);
      end
      n_checks++;
      if ({equal, error} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_start_clear: equal/error got %b want 00", tag, {equal, error});
      end
      for (int i = 0; i < n_words; i++) begin
         in_valid = 1'b1;
         in_addr  = stim_addr[i];
         in_data  = stim_data[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_done  = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      lat = done ? 1 : -1;
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         if (done && lat < 0) lat = k;
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy_end: got %b want 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({wr_en, busy, done, equal, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en/busy/done/eq/err=%b addr=%0h data=%0h want all 0",
                  {wr_en, busy, done, equal, error}, wr_addr, wr_data);
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== '0) begin
         n_fail++;
         $display("FAIL reset_weight: got %0d want 0", weight);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_ignore();
      wr_cnt = 0; done_cnt = 0;
      in_valid = 1'b1; in_addr = '0; in_data = '1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0; in_done = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (wr_cnt !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore: writes=%0d dones=%0d busy=%b want 0/0/0", wr_cnt, done_cnt, busy);
      end
   endtask

   task automatic test_zero_stream();
      int lat;
      clear_stim();
      run_stream("zero", DEPTH + 1, lat);
      n_checks++;
      if (wr_cnt !== DEPTH || seq_err !== 0 || bad_addr !== 0) begin
         n_fail++;
         $display("FAIL zero_writes: count=%0d seq_err=%0d bad_addr=%0d want 139/0/0",
                  wr_cnt, seq_err, bad_addr);
      end
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL zero_done_latency: got %0d want 3", lat);
      end
      n_checks++;
      if ({equal, error} !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_verdict: equal/error got %b want 10", {equal, error});
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if ({equal, error} !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_verdict_hold: equal/error got %b want 10", {equal, error});
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== 15'd0) begin
         n_fail++;
         $display("FAIL zero_weight: got %0d want 0", weight);
      end
`endif
   endtask

   // All-ones last word: only bits [4:0] survive trimming, so equal drops.
   task automatic test_tail_ones();
      int lat;
      clear_stim();
      stim_data[138] = '1;
      run_stream("tail_ones", DEPTH + 1, lat);
      n_checks++;
      if (mem[138] !== 128'h1F) begin
         n_fail++;
         $display("FAIL tail_ones_data: got %0h want 1f", mem[138]);
      end
      n_checks++;
      if ({equal, error} !== 2'b00) begin
         n_fail++;
         $display("FAIL tail_ones_verdict: equal/error got %b want 00", {equal, error});
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== 15'd5) begin
         n_fail++;
         $display("FAIL tail_ones_weight: got %0d want 5", weight);
      end
`endif
   endtask

   // Difference confined to padding bits [127:5]: trims to zero, still equal.
   task automatic test_padding_only();
      int lat;
      logic [WIDTH-1:0] pad;
      pad = ~128'h1F;
      clear_stim();
      stim_data[138] = pad;
      run_stream("padding", DEPTH + 1, lat);
      n_checks++;
      if (mem[138] !== '0) begin
         n_fail++;
         $display("FAIL padding_data: got %0h want 0", mem[138]);
      end
      n_checks++;
      if ({equal, error} !== 2'b10) begin
         n_fail++;
         $display("FAIL padding_verdict: equal/error got %b want 10", {equal, error});
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== 15'd0) begin
         n_fail++;
         $display("FAIL padding_weight: got %0d want 0", weight);
      end
`endif
   endtask

   task automatic test_single_bit();
      int lat;
      clear_stim();
      stim_data[57] = 128'h1;
      stim_data[137] = {1'b1, 127'h0};   // top bit of a non-last word is kept
      run_stream("single_bit", DEPTH + 1, lat);
      n_checks++;
      if (mem[57] !== 128'h1 || mem[137] !== {1'b1, 127'h0}) begin
         n_fail++;
         $display("FAIL single_bit_data: w57=%0h w137=%0h want 1 / 8000..0", mem[57], mem[137]);
      end
      n_checks++;
      if ({equal, error} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_bit_verdict: equal/error got %b want 00", {equal, error});
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== 15'd2) begin
         n_fail++;
         $display("FAIL single_bit_weight: got %0d want 2", weight);
      end
`endif
   endtask

   task automatic test_addr_skip();
      int lat;
      clear_stim();
      stim_addr[10] = 8'd11;
      run_stream("addr_skip", 11, lat);
      n_checks++;
      if ({equal, error} !== 2'b01) begin
         n_fail++;
         $display("FAIL addr_skip_verdict: equal/error got %b want 01", {equal, error});
      end
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL addr_skip_done_latency: got %0d want 3", lat);
      end
   endtask

   task automatic test_early_done();
      int lat;
      clear_stim();
      run_stream("early_done", 100, lat);
      n_checks++;
      if (wr_cnt !== 100) begin
         n_fail++;
         $display("FAIL early_done_writes: got %0d want 100", wr_cnt);
      end
      n_checks++;
      if ({equal, error} !== 2'b01) begin
         n_fail++;
         $display("FAIL early_done_verdict: equal/error got %b want 01", {equal, error});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      clear_stim();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_cnt = 0; exp_addr = 0; seq_err = 0;
      for (int i = 0; i < 70; i++) begin
         in_valid = 1'b1;
         in_addr  = stim_addr[i];
         in_data  = '1;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_addr  = 8'd70;
      in_data  = '1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({wr_en, busy, done, equal, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got en/busy/done/eq/err=%b addr=%0h data=%0h want all 0",
                  {wr_en, busy, done, equal, error}, wr_addr, wr_data);
      end
`ifdef XOR_CMP_WEIGHT_EN
      n_checks++;
      if (weight !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_weight: got %0d want 0", weight);
      end
`endif
      n_checks++;
      if (wr_cnt !== 70) begin
         n_fail++;
         $display("FAIL reset_mid_pre_writes: got %0d want 70", wr_cnt);
      end
      wr_cnt = 0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (wr_cnt !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: writes=%0d busy=%b want 0/0", wr_cnt, busy);
      end
      clear_stim();
      run_stream("after_reset", DEPTH + 1, lat);
      n_checks++;
      if ({equal, error} !== 2'b10 || wr_cnt !== DEPTH) begin
         n_fail++;
         $display("FAIL after_reset_verdict: equal/error=%b writes=%0d want 10/139",
                  {equal, error}, wr_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_zero_stream();
      test_tail_ones();
      test_padding_only();
      test_single_bit();
      test_addr_skip();
      test_early_done();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_xor_stream_compare
